// File: rtl/im_fetch_ctrl.sv
// im_fetch_ctrl: instruction fetch sequencer in front of a synchronous-read IM.
// Owns the fetch PC and issues at most one IM read per cycle. Read data
// returns one cycle later and lands in a 2-entry output buffer that feeds
// decode. Redirects flush everything in flight, and debug halt pauses issue.
//
// Handshake (decode side): a transfer happens in any cycle where
// if_valid && if_ready. While if_valid is high and if_ready is low, if_pc
// and if_instr hold their values. if_valid never depends on if_ready.
module im_fetch_ctrl #(
  parameter int                    ARCH_WIDTH = 32,
  parameter int                    IM_WIDTH   = 32,
  parameter logic [ARCH_WIDTH-1:0] RESET_PC   = 32'h0000_3000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  im_en,
  output logic [ARCH_WIDTH-1:0] im_addr,
  input  logic [IM_WIDTH-1:0]   im_dout,
  input  logic                  redirect_valid,
  input  logic [ARCH_WIDTH-1:0] redirect_pc,
  input  logic                  halt,
  output logic                  if_valid,
  input  logic                  if_ready,
  output logic [ARCH_WIDTH-1:0] if_pc,
  output logic [IM_WIDTH-1:0]   if_instr,
  output logic                  misalign,
  output logic                  halted,
  output logic [1:0]            state_dbg
);

  typedef enum logic [1:0] {
    ST_WAKE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t                state;
  logic [ARCH_WIDTH-1:0] pc_q;
  logic [ARCH_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  logic                  misalign_q;

  // Output buffer: entry 0 is always the head; occ counts valid entries.
  logic [1:0]            occ;
  logic [ARCH_WIDTH-1:0] buf_pc0, buf_pc1;
  logic [IM_WIDTH-1:0]   buf_ins0, buf_ins1;

  logic       redir;
  logic       pop;
  logic       pop_eff;
  logic       push;
  logic       issue;
  logic [2:0] pending;

  // Redirects are ignored during the post-reset wake cycle.
  assign redir   = redirect_valid & (state != ST_WAKE);
  assign pop     = if_valid & if_ready;
  assign pop_eff = pop & ~redir;
  assign push    = inflight & ~redir;

  // Entries that will occupy the buffer once this cycle settles. An issue is
  // allowed only if its data is guaranteed a slot when it returns.
  assign pending = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign issue   = (state == ST_RUN) & ~halt & ~redirect_valid & (pending < 3'd2);

  assign im_en     = issue;
  assign im_addr   = pc_q;
  assign if_valid  = (occ != 2'd0);
  assign if_pc     = buf_pc0;
  assign if_instr  = buf_ins0;
  assign misalign  = misalign_q;
  assign halted    = (state == ST_HALT) & ~inflight;
  assign state_dbg = state;

  // Control FSM: one idle wake cycle after reset, then run or halt.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_WAKE;
    end else begin
      case (state)
        ST_WAKE: state <= ST_RUN;
        ST_RUN:  if (halt) state <= ST_HALT;
        ST_HALT: if (!halt) state <= ST_RUN;
        default: state <= ST_WAKE;
      endcase
    end
  end

  // Fetch PC, in-flight tracking and the misalign pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
      misalign_q  <= 1'b0;
    end else begin
      misalign_q <= 1'b0;
      if (redir) begin
        pc_q       <= {redirect_pc[ARCH_WIDTH-1:2], 2'b00};
        misalign_q <= |redirect_pc[1:0];
        inflight   <= 1'b0;
      end else if (issue) begin
        pc_q        <= pc_q + ARCH_WIDTH'(4);
        inflight    <= 1'b1;
        inflight_pc <= pc_q;
      end else begin
        inflight <= 1'b0;
      end
    end
  end

  // Two-entry output FIFO; a push and a pop in the same cycle both take effect.
  always_ff @(posedge clk) begin
    if (rst || redir) begin
      occ <= 2'd0;
    end else begin
      case ({push, pop_eff})
        2'b10: begin
          if (occ == 2'd0) begin
            buf_pc0  <= inflight_pc;
            buf_ins0 <= im_dout;
          end else begin
            buf_pc1  <= inflight_pc;
            buf_ins1 <= im_dout;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf_pc0  <= buf_pc1;
          buf_ins0 <= buf_ins1;
          occ      <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf_pc0  <= inflight_pc;
            buf_ins0 <= im_dout;
          end else begin
            buf_pc0  <= buf_pc1;
            buf_ins0 <= buf_ins1;
            buf_pc1  <= inflight_pc;
            buf_ins1 <= im_dout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
